// File: rtl/serial_add_seq.sv
// Multi-cycle WIDTH-bit adder (A + B + Cin) that reuses one external 2-bit
// carry-chain slice, LSB pair first.
//
// state | meaning
// IDLE  | waiting for start; slice inputs held at 0
// RUN   | one operand pair per cycle through the slice; busy=1
// DONE  | one-cycle done pulse; sum/cout valid; start may retrigger
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       slice_a,
  output logic [1:0]       slice_b,
  output logic             slice_cin,
  input  logic [1:0]       slice_sum,
  input  logic             slice_cout
);

  localparam int HALF  = WIDTH / 2;
  localparam int CNT_W = $clog2(HALF) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HALF - 1);

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("serial_add_seq: WIDTH must be even and >= 2");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] op_a_q,   op_a_d;
  logic [WIDTH-1:0] op_b_q,   op_b_d;
  logic             carry_q,  carry_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] sum_q,    sum_d;
  logic             cout_q,   cout_d;

  // New slice result enters at the top; after HALF shifts the LSB pair
  // produced first has reached bit 0.
  logic [WIDTH-1:0] acc_next;
  assign acc_next = WIDTH'({slice_sum, acc_q} >> 2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    carry_d   = carry_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    slice_a   = 2'b00;
    slice_b   = 2'b00;
    slice_cin = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // start beats abort here; abort only matters mid-run
        if (start) begin
          op_a_d  = a;
          op_b_d  = b;
          carry_d = cin;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        slice_a   = op_a_q[1:0];
        slice_b   = op_b_q[1:0];
        slice_cin = carry_q;
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          acc_d   = acc_next;
          carry_d = slice_cout;
          op_a_d  = op_a_q >> 2;
          op_b_d  = op_b_q >> 2;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            sum_d   = acc_next;
            cout_d  = slice_cout;
            state_d = ST_DONE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: doc/serial_add_seq.md
Name: serial_add_seq

Overview:
- Sequencer that performs a WIDTH-bit add (A + B + Cin) by time-multiplexing one external 2-bit carry-in/carry-out adder slice, 2 bits per clock, LSB pair first.
- The slice sits outside this block, and this block owns its inputs.
- Sits between a requester (start/done handshake) and the slice. Trades latency for reuse of the single combinational slice.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 2. Elaboration fails otherwise.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled on clk edge when state is IDLE or DONE
- abort  in  1  synchronous cancel of an in-progress add
- a  in  WIDTH  operand A, captured on accepted start
- b  in  WIDTH  operand B, captured on accepted start
- cin  in  1  carry in, captured on accepted start
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse; sum/cout valid from this cycle
- sum  out  WIDTH  registered result, held until next completion
- cout  out  1  registered final carry, held until next completion
- slice_a  out  2  to slice operand A
- slice_b  out  2  to slice operand B
- slice_cin  out  1  to slice carry in
- slice_sum  in  2  from slice sum
- slice_cout  in  1  from slice carry out

Behaviour:
- Reset:
  - Reset (reset_n=0, async) -> state IDLE, busy=0, done=0, sum=0, cout=0.
  - Internal operand/accumulator/carry/count registers are 0.
  - Reset mid-RUN discards the operation; no done.
- States are IDLE, RUN and DONE.
- IDLE:
  - start=1 at edge -> capture a, b, cin into opA, opB, carry; clear cnt and acc; go to RUN.
- RUN:
  - Combinationally: slice_a=opA[1:0], slice_b=opB[1:0], slice_cin=carry.
  - Each edge:
    - acc <= {slice_sum, acc[WIDTH-1:2]}
    - carry <= slice_cout
    - opA, opB shift right by 2
    - cnt++
  - On the edge where cnt == WIDTH/2-1:
    - sum <= {slice_sum, acc[WIDTH-1:2]}
    - cout <= slice_cout
    - done <= 1
    - go to DONE
- DONE:
  - done=1 for exactly this one cycle; busy=0.
  - start=1 here is accepted exactly as in IDLE (back-to-back, no bubble); done still deasserts next cycle.
  - Otherwise go to IDLE.
- Slice inputs are driven 0 in IDLE and DONE.
- Latency:
  - Accepted start at edge E0 -> busy=1 after E0 through E(WIDTH/2).
  - sum, cout and done update at edge E(WIDTH/2).
  - For WIDTH=8: done visible after 4 RUN edges, i.e. 5th edge counting the start edge.
- start while busy: ignored, no effect on operands.
- abort=1 at an edge in RUN -> go to IDLE.
  - No done; sum and cout keep their previous values.
  - abort has priority over completion on the final RUN edge.
  - abort is ignored in IDLE and DONE.
- start and abort both high in IDLE/DONE -> start wins.
- Width rules:
  - cnt width = clog2(WIDTH/2)+1, so it never wraps during a run.
  - The result is modulo 2^WIDTH with the carry in cout; there is no other overflow signal.
- Operands a, b and cin may change freely after the start edge; only captured values are used.

Test Plan:
- WIDTH=8, a=0x12, b=0x34, cin=0, start pulse -> busy 4 cycles, done pulse at 5th edge, sum=0x46, cout=0.
- a=0xFF, b=0x01, cin=0 -> carry ripples every pair; sum=0x00, cout=1. Check slice_cin sequence per RUN cycle = 0, 1, 1, 1.
- a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1.
- Second run a=0x01, b=0x01, cin=0 started during the DONE cycle -> no idle cycle, done one cycle, then sum=0x02.
- Race cases:
  - start pulsed while busy -> ignored; the original result is unaffected.
  - abort on the 2nd RUN cycle -> IDLE, no done, sum holds the prior 0x46.
  - abort on the final RUN edge -> no done, sum unchanged.
- reset_n low mid-RUN (async, between edges) -> busy, done, sum and cout go to 0 immediately; after release, a new start with 0x0F+0x01 -> sum=0x10, cout=0.
